adder_rr_scheduler: RTL

Round-robin scheduler that shares one 64-bit Brent-Kung adder (`sixty_four_bit_brentkung`) between NREQ requesters. It accepts one add/subtract request at a time over per-requester valid/ready handshakes. It configures the adder operands for add or subtract, registers operands and result, and returns sum, carry and signed overflow tagged with the requester ID on a single response port. It sits between the adder datapath and the client blocks that need 64-bit additions.

---
 rtl/adder_rr_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one registered 64-bit Brent-Kung adder among NREQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (add) -> RESP (hold until accepted).
module adder_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, id_q;
  logic [63:0]     opa_q, opb_q, rsp_sum_q;
  logic            opcin_q, sub_q, rsp_cout_q, rsp_ovf_q;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] win;
  logic            found, accept;
  logic [63:0]     sel_a, sel_b;
  logic            sel_cin, sel_sub;

  // Winner is the first valid requester at or above ptr, wrapping modulo NREQ.
  always_comb begin : p_arb
    int k;
    k     = 0;
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req_valid[k]) begin
        found  = 1'b1;
        win    = ID_W'(k);
        gnt[k] = 1'b1;
      end
    end
  end

  always_comb begin : p_mux
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[64*i +: 64];
        sel_b   = req_b[64*i +: 64];
        sel_cin = req_cin[i];
        sel_sub = req_sub[i];
      end
    end
  end

  assign accept    = (state_q == StIdle) && found;
  assign req_ready = (state_q == StIdle && !rst) ? gnt : '0;

  always_comb begin : p_fsm
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Brent-Kung prefix network over the registered operands.
  logic [63:0]        beff, bit_g, bit_p, sum;
  logic               cin_eff, cout, ovf;
  logic [11:0][63:0]  gs;
  logic [10:0][63:0]  ps;

  assign beff    = sub_q ? ~opb_q : opb_q;
  assign cin_eff = sub_q ? 1'b1 : opcin_q;
  assign bit_g   = opa_q & beff;
  assign bit_p   = opa_q ^ beff;
  // Carry-in folded into bit 0 so every prefix G[i] is the carry out of bit i.
  assign gs[0]   = bit_g | {63'd0, bit_p[0] & cin_eff};
  assign ps[0]   = bit_p;

  for (genvar s = 1; s <= 11; s++) begin : g_stage
    for (genvar i = 0; i < 64; i++) begin : g_bit
      localparam int  L    = (s <= 6) ? s - 1 : 11 - s;
      localparam int  D    = 2 ** L;
      localparam bit  Comb = (s <= 6) ? (((i + 1) % (2 * D)) == 0)
                                      : ((i >= 2 * D) && (((i + 1) % (2 * D)) == D));
      if (Comb) begin : g_op
        assign gs[s][i] = gs[s-1][i] | (ps[s-1][i] & gs[s-1][i-D]);
        if (s <= 6) begin : g_pu
          assign ps[s][i] = ps[s-1][i] & ps[s-1][i-D];
        end else if (s <= 10) begin : g_pd
          assign ps[s][i] = ps[s-1][i];
        end
      end else begin : g_pass
        assign gs[s][i] = gs[s-1][i];
        if (s <= 10) begin : g_pp
          assign ps[s][i] = ps[s-1][i];
        end
      end
    end
  end

  assign sum  = bit_p ^ {gs[11][62:0], cin_eff};
  assign cout = gs[11][63];
  assign ovf  = (opa_q[63] == beff[63]) && (sum[63] != opa_q[63]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      id_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      opcin_q    <= 1'b0;
      sub_q      <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q   <= sel_a;
        opb_q   <= sel_b;
        opcin_q <= sel_cin;
        sub_q   <= sel_sub;
        id_q    <= win;
        ptr_q   <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
      end
      if (state_q == StExec) begin
        rsp_sum_q  <= sum;
        rsp_cout_q <= cout;
        rsp_ovf_q  <= ovf;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != StIdle);

endmodule
